eeprom_i2c_engine: RTL and testbench
====================================

# eeprom_i2c_engine

Bit-level I2C master that executes one 24Cxx-style EEPROM transaction per `start` pulse: random-address write or random-address read of 0–255 bytes. It sits directly downstream of the EEPROM interface core's FIFOs. Write bytes come from the TX FIFO via a pop-request handshake, and read bytes go to the RX FIFO via a push strobe. It drives the board SCL/SDA pins in open-drain style. SCL is generated from `clk` by a clock enable; there is no derived clock.

## Interface
- `CLK_DIV`, 125: `clk` cycles per quarter SCL period (125 at 50 MHz gives 100 kHz SCL); legal range 2–1023.
- `DEV_ADDR`, 7'h50: 7-bit I2C device address.

- `clk` in 1: system clock.
- `reset_l` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; ignored while `busy`=1.
- `rw` in 1: 1 = read, 0 = write; sampled with `start`.
- `nbytes` in 8: data byte count; sampled with `start`.
- `addr_hi` in 8: word address high byte; sampled with `start`.
- `addr_lo` in 8: word address low byte; sampled with `start`.
- `write_data` in 8: next TX byte; must be valid in the same cycle as `tx_data_req` (FWFT).
- `tx_data_req` out 1: one-cycle pulse that consumes `write_data`.
- `read_data` out 8: last received byte; held until the next byte arrives.
- `rx_data_ready` out 1: one-cycle pulse; `read_data` is valid in the same cycle.
- `busy` out 1: high from the cycle after an accepted `start` until `completed`.
- `completed` out 1: one-cycle pulse at the end of a transaction.
- `nack_err` out 1: set on a slave NACK; cleared by the next accepted `start`.
- `scl` out 1: SCL level (board drives it push-pull or through an OD buffer).
- `sda_oe` out 1: 1 = pull SDA low; 0 = release.
- `sda_in` in 1: SDA pin level; double-flop synchronised internally.

## Operation
- **Tick generator.** A counter runs 0..`CLK_DIV`-1 only while `busy`. The tick asserts when the counter wraps. Each bit is 4 ticks (quarters q0–q3).
  - q0: SCL low; SDA changes.
  - q1: SCL rises.
  - q2: sample the synchronised `sda_in`.
  - q3: SCL falls.
- **States:** IDLE, START, DEV_W, ADDR_H, ADDR_L, WDATA, RSTART, DEV_R, RDATA, STOP, DONE.
- **Byte states.** Each byte state shifts 8 bits MSB first, then 1 ACK bit, for 36 ticks total.
- **START / RSTART sequence:** q0 release SDA with SCL low → q1 SCL high → q2 SDA low → q3 SCL low.
- **STOP sequence:** q0 SDA low → q1 SCL high → q2 release SDA → q3 go to DONE.
- **Transitions:**
  - IDLE→START on accepted `start`.
  - START→DEV_W→ADDR_H→ADDR_L.
  - From ADDR_L:
    - `nbytes`=0 → STOP (address-pointer set only, both for reads and writes).
    - write → WDATA.
    - read → RSTART→DEV_R→RDATA.
  - WDATA and RDATA repeat until the byte counter reaches 0, then → STOP.
  - DONE → IDLE after one `clk` cycle.
- **Address bytes.** DEV_W sends {`DEV_ADDR`,0}. DEV_R sends {`DEV_ADDR`,1}.
- **TX handshake.** `tx_data_req` pulses in the `clk` cycle where a WDATA byte's q0 tick begins. `write_data` is loaded into the shift register in that same cycle.
- **Read ACK policy.** The master drives ACK (SDA low) after every RDATA byte except the last, where it sends NACK (SDA released).
- **RX handshake.** `rx_data_ready` pulses on the tick at the end of the byte's 8th-bit q2 sample.
- **Slave NACK.** A NACK on DEV_W, ADDR_H, ADDR_L, WDATA or DEV_R sets `nack_err` and jumps to STOP at the next q0. No further `tx_data_req` or `rx_data_ready` pulses follow.
- **Byte counter.** 8-bit, loaded from `nbytes`, decremented per data byte; no wrap is possible.

## Timing
- **Reset values:** `scl`=1, `sda_oe`=0, `busy`=0, `completed`=0, `nack_err`=0, `read_data`=0, `tx_data_req`=0, `rx_data_ready`=0; state IDLE; tick counter 0.
- **Reset mid-transaction:** pins are released immediately (asynchronously). No STOP is generated and no `completed` pulse is produced.
- **`start` latency:** `busy` rises 1 cycle after `start`. The first tick comes `CLK_DIV` cycles later.
- **Transaction length in ticks** (T = `CLK_DIV` clk):
  - Write: 4 + 36·(3+N) + 4.
  - Read with N>0: 4 + 108 + 4 + 36 + 36·N + 4.
  - N=0: 4 + 108 + 4.
- **End of transaction:** `completed` pulses 1 cycle after the STOP q3 tick. `busy` falls in that same cycle.
- **`start` during `completed`:** a `start` asserted in the same cycle as `completed` is ignored.
- **Output registering:** `scl` and `sda_oe` change only on tick cycles and are registered (no glitches).

## Test plan
- **Write, N=2.** `CLK_DIV`=4, `addr`=0x0123, TX bytes 0xA5, 0x3C, slave ACKs everything.
  - Bus shows START, 0xA0, 0x01, 0x23, 0xA5, 0x3C, STOP.
  - Exactly 2 `tx_data_req` pulses; `completed` arrives after 188 ticks; `nack_err`=0.
- **Read, N=3.** `addr`=0x0010, slave returns 0x11, 0x22, 0x33.
  - Bus shows 0xA0, 0x00, 0x10, RSTART, 0xA1.
  - `rx_data_ready` pulses 3 times with `read_data` 0x11, 0x22, 0x33.
  - Master ACKs bytes 1–2 and NACKs byte 3.
- **Slave NACK on ADDR_L (write, N=4).** Response: STOP immediately after that byte, `nack_err`=1, zero `tx_data_req` pulses, `completed` pulses once.
- **Address-only, N=0 (read).** Response: no RSTART; STOP after ADDR_L; `completed` after 116 ticks.
- **Busy and restart.** `start` re-pulsed while `busy` → ignored and parameters unchanged. A new `start` after `completed` clears `nack_err`.
- **Reset mid-transaction.** Assert `reset_l`=0 during WDATA bit 5: `scl`=1 and `sda_oe`=0 at once. After release, `busy`=0 and the next `start` produces a clean transaction.

Source files
------------

// File: rtl/eeprom_i2c_engine.sv
// Bit-level I2C master running one 24Cxx random-address write or read per start pulse.
// SCL comes from a quarter-period clock enable on clk; SDA is open-drain via sda_oe.
module eeprom_i2c_engine #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] nbytes,
  input  logic [7:0] addr_hi,
  input  logic [7:0] addr_lo,
  input  logic [7:0] write_data,
  output logic       tx_data_req,
  output logic [7:0] read_data,
  output logic       rx_data_ready,
  output logic       busy,
  output logic       completed,
  output logic       nack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);

  // state  | meaning
  // IDLE, DONE         | waiting / one-cycle completion
  // START, RSTART, STOP| bus conditions, 4 ticks each
  // DEV_W..RDATA       | byte states: 8 data bits + ACK, 36 ticks
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_DEV_W  = 4'd2;
  localparam logic [3:0] S_ADDR_H = 4'd3;
  localparam logic [3:0] S_ADDR_L = 4'd4;
  localparam logic [3:0] S_WDATA  = 4'd5;
  localparam logic [3:0] S_RSTART = 4'd6;
  localparam logic [3:0] S_DEV_R  = 4'd7;
  localparam logic [3:0] S_RDATA  = 4'd8;
  localparam logic [3:0] S_STOP   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  logic [3:0] state;
  logic [3:0] next_after_byte;
  logic [1:0] qtr;
  logic [3:0] bit_idx;
  logic [9:0] div_cnt;
  logic       tick;
  logic       sda_meta;
  logic       sda_sync;
  logic [7:0] shift;
  logic [7:0] bytes_left;
  logic [7:0] addr_hi_r;
  logic [7:0] addr_lo_r;
  logic [7:0] rd_hold;
  logic [7:0] byte_src;
  logic       rw_r;
  logic       slave_nack;
  logic       byte_state;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)
      div_cnt <= '0;
    else if (!busy || div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 10'd1;
  end

  assign tick       = busy && (div_cnt == DIV_LAST);
  assign byte_state = state inside {S_DEV_W, S_ADDR_H, S_ADDR_L, S_WDATA, S_DEV_R, S_RDATA};

  assign tx_data_req   = tick && (state == S_WDATA) && (qtr == 2'd0) && (bit_idx == 4'd0);
  assign rx_data_ready = tick && (state == S_RDATA) && (qtr == 2'd2) && (bit_idx == 4'd7);
  assign read_data     = rx_data_ready ? {shift[6:0], sda_sync} : rd_hold;
  assign completed     = (state == S_DONE);

  always_comb begin
    byte_src = shift;
    case (state)
      S_DEV_W:  byte_src = {DEV_ADDR, 1'b0};
      S_ADDR_H: byte_src = addr_hi_r;
      S_ADDR_L: byte_src = addr_lo_r;
      S_WDATA:  byte_src = write_data;
      S_DEV_R:  byte_src = {DEV_ADDR, 1'b1};
      default:  byte_src = shift;
    endcase
  end

  // Any slave NACK diverts to STOP; RDATA acks are ours, so only the count matters there.
  always_comb begin
    next_after_byte = S_STOP;
    case (state)
      S_DEV_W:  if (!slave_nack) next_after_byte = S_ADDR_H;
      S_ADDR_H: if (!slave_nack) next_after_byte = S_ADDR_L;
      S_ADDR_L: if (!slave_nack && bytes_left != 8'd0)
                  next_after_byte = rw_r ? S_RSTART : S_WDATA;
      S_WDATA:  if (!slave_nack && bytes_left != 8'd1) next_after_byte = S_WDATA;
      S_DEV_R:  if (!slave_nack) next_after_byte = S_RDATA;
      S_RDATA:  if (bytes_left != 8'd1) next_after_byte = S_RDATA;
      default:  next_after_byte = S_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      qtr        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      bytes_left <= '0;
      addr_hi_r  <= '0;
      addr_lo_r  <= '0;
      rd_hold    <= '0;
      rw_r       <= 1'b0;
      slave_nack <= 1'b0;
      busy       <= 1'b0;
      nack_err   <= 1'b0;
      scl        <= 1'b1;
      sda_oe     <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state      <= S_START;
        busy       <= 1'b1;
        nack_err   <= 1'b0;
        rw_r       <= rw;
        bytes_left <= nbytes;
        addr_hi_r  <= addr_hi;
        addr_lo_r  <= addr_lo;
        qtr        <= '0;
        bit_idx    <= '0;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end else if (tick) begin
      qtr <= qtr + 2'd1;
      if (byte_state) begin
        case (qtr)
          2'd0: begin
            scl <= 1'b0;
            if (bit_idx == 4'd8)
              sda_oe <= (state == S_RDATA) && (bytes_left != 8'd1);
            else if (state == S_RDATA)
              sda_oe <= 1'b0;
            else if (bit_idx == 4'd0) begin
              shift  <= byte_src;
              sda_oe <= ~byte_src[7];
            end else
              sda_oe <= ~shift[7];
          end
          2'd1: scl <= 1'b1;
          2'd2: begin
            if (bit_idx != 4'd8)
              shift <= {shift[6:0], sda_sync};
            else if (state != S_RDATA) begin
              slave_nack <= sda_sync;
              if (sda_sync) nack_err <= 1'b1;
            end
            if (rx_data_ready) rd_hold <= {shift[6:0], sda_sync};
          end
          default: begin
            scl <= 1'b0;
            if (bit_idx != 4'd8)
              bit_idx <= bit_idx + 4'd1;
            else begin
              bit_idx <= '0;
              if (state == S_WDATA || state == S_RDATA) bytes_left <= bytes_left - 8'd1;
              state <= next_after_byte;
            end
          end
        endcase
      end else begin
        case (qtr)
          2'd0: begin
            scl    <= 1'b0;
            sda_oe <= (state == S_STOP);
          end
          2'd1: scl <= 1'b1;
          2'd2: sda_oe <= (state != S_STOP);
          default: begin
            if (state == S_STOP) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              scl   <= 1'b0;
              state <= (state == S_START) ? S_DEV_W : S_DEV_R;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_engine.sv
// Self-checking bench: per-tick pin waveform model built from bus-level byte sequences,
// checked every cycle, plus directed test-plan cases and randomized transactions.
module tb_eeprom_i2c_engine;

  localparam int         D   = 4;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       start;
  logic       rw;
  logic [7:0] nbytes;
  logic [7:0] addr_hi;
  logic [7:0] addr_lo;
  logic [7:0] write_data;
  logic       tx_data_req;
  logic [7:0] read_data;
  logic       rx_data_ready;
  logic       busy;
  logic       completed;
  logic       nack_err;
  logic       scl;
  logic       sda_oe;
  logic       sda_in;
  logic       slave_pull = 1'b0;

  eeprom_i2c_engine #(.CLK_DIV(D), .DEV_ADDR(DEV)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .rw(rw), .nbytes(nbytes),
    .addr_hi(addr_hi), .addr_lo(addr_lo), .write_data(write_data),
    .tx_data_req(tx_data_req), .read_data(read_data), .rx_data_ready(rx_data_ready),
    .busy(busy), .completed(completed), .nack_err(nack_err), .scl(scl),
    .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: either side can pull SDA low.
  assign sda_in = ~sda_oe & ~slave_pull;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TX FIFO in first-word-fall-through form.
  logic [7:0] tx_mem [0:255];
  logic [7:0] tx_pops = 8'd0;
  assign write_data = tx_mem[tx_pops];
  always @(posedge clk) if (tx_data_req) tx_pops <= tx_pops + 8'd1;

  // Expected state after tick k (index 0 = before the first tick).
  bit         m_scl[$], m_oe[$], m_pull[$], m_tx[$], m_rx[$];
  logic [7:0] m_rv[$];
  int         T = 0;
  int         P = 0;
  int         mode = 2;
  bit         exp_nack = 1'b0;
  bit         idle_nack = 1'b0;
  logic [7:0] wr_bytes [0:7];
  logic [7:0] rd_bytes [0:7];

  int         tx_seen = 0, rx_seen = 0, done_seen = 0, done_cyc = 0;
  logic [7:0] rx_got [0:255];
  int         rr, qi, kk;
  bit         etx, erx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_q(input bit s, input bit o, input bit p, input bit t, input bit r,
                        input logic [7:0] v);
    m_scl.push_back(s); m_oe.push_back(o); m_pull.push_back(p);
    m_tx.push_back(t);  m_rx.push_back(r); m_rv.push_back(v);
  endtask

  task automatic add_cond(input bit is_stop);
    if (!is_stop) begin
      push_q(0,0,0,0,0,0); push_q(1,0,0,0,0,0); push_q(1,1,0,0,0,0); push_q(0,1,0,0,0,0);
    end else begin
      push_q(0,1,0,0,0,0); push_q(1,1,0,0,0,0); push_q(1,0,0,0,0,0); push_q(1,0,0,0,0,0);
    end
  endtask

  task automatic add_bit(input bit oe, input bit pull, input bit tx_q0, input bit rx_q2,
                         input logic [7:0] v);
    push_q(0, oe, pull, tx_q0, 0, 0);
    push_q(1, oe, pull, 0, 0, 0);
    push_q(1, oe, pull, 0, rx_q2, v);
    push_q(0, oe, pull, 0, 0, 0);
  endtask

  task automatic add_mbyte(input logic [7:0] v, input bit is_tx, input bit nack);
    for (int i = 0; i < 8; i++) add_bit(~v[7-i], 1'b0, is_tx && i == 0, 1'b0, 8'h00);
    add_bit(1'b0, ~nack, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic add_sbyte(input logic [7:0] v, input bit last);
    for (int i = 0; i < 8; i++) add_bit(1'b0, ~v[7-i], 1'b0, i == 7, v);
    add_bit(~last, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic build_model(input bit wr_rd, input int n, input logic [7:0] ah,
                             input logic [7:0] al, input int nack_at);
    logic [7:0] seq_v[$];
    bit         seq_tx[$];
    bit         aborted;
    m_scl.delete(); m_oe.delete(); m_pull.delete(); m_tx.delete(); m_rx.delete(); m_rv.delete();
    push_q(1,0,0,0,0,0);
    add_cond(1'b0);
    seq_v = '{{DEV, 1'b0}, ah, al};
    seq_tx = '{1'b0, 1'b0, 1'b0};
    if (!wr_rd)
      for (int i = 0; i < n; i++) begin seq_v.push_back(wr_bytes[i]); seq_tx.push_back(1'b1); end
    aborted = 1'b0;
    for (int i = 0; i < seq_v.size() && !aborted; i++) begin
      add_mbyte(seq_v[i], seq_tx[i], nack_at == i);
      if (nack_at == i) aborted = 1'b1;
    end
    if (!aborted && wr_rd && n > 0) begin
      add_cond(1'b0);
      add_mbyte({DEV, 1'b1}, 1'b0, nack_at == 3);
      if (nack_at == 3) aborted = 1'b1;
      else for (int i = 0; i < n; i++) add_sbyte(rd_bytes[i], i == n - 1);
    end
    add_cond(1'b1);
    exp_nack = aborted;
    T = m_scl.size() - 1;
  endtask

  always @(negedge clk) begin
    if (mode == 2) begin
      slave_pull = 1'b0;
      idle_nack  = 1'b0;
    end else begin
      rr = cyc - P;
      if (mode == 1 && rr >= 0 && rr <= T * D) begin
        if (rr == 0) begin tx_seen = 0; rx_seen = 0; done_seen = 0; end
        qi = rr / D;
        slave_pull = m_pull[qi];
        kk  = (rr + 1) / D;
        etx = ((rr + 1) % D == 0) && kk <= T && m_tx[kk];
        erx = ((rr + 1) % D == 0) && kk <= T && m_rx[kk];
        chk("scl", scl, m_scl[qi]);
        chk("sda_oe", sda_oe, m_oe[qi]);
        chk("busy", busy, rr < T * D);
        chk("completed", completed, rr == T * D);
        chk("tx_data_req", tx_data_req, etx);
        chk("rx_data_ready", rx_data_ready, erx);
        if (erx) chk("read_data", read_data, m_rv[kk]);
        if (rr < D) chk("nack_clear", nack_err, 1'b0);
        if (rr == T * D) begin
          chk("nack_end", nack_err, exp_nack);
          idle_nack = exp_nack;
        end
      end else begin
        slave_pull = 1'b0;
        chk("idle_scl", scl, 1'b1);
        chk("idle_sda_oe", sda_oe, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_completed", completed, 1'b0);
        chk("idle_tx", tx_data_req, 1'b0);
        chk("idle_rx", rx_data_ready, 1'b0);
        chk("idle_nack", nack_err, idle_nack);
      end
      if (tx_data_req) tx_seen++;
      if (rx_data_ready) begin rx_got[rx_seen[7:0]] = read_data; rx_seen++; end
      if (completed) begin done_seen++; done_cyc = cyc; end
    end
  end

  always @(posedge clk) begin
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d, expected below 90000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  task automatic begin_txn(input bit wr_rd, input int n, input logic [7:0] ah,
                           input logic [7:0] al, input int nack_at);
    @(posedge clk); #1;
    mode = 0;
    build_model(wr_rd, n, ah, al, nack_at);
    for (int i = 0; i < n; i++) tx_mem[8'(tx_pops + 8'(i))] = wr_bytes[i];
    rw = wr_rd; nbytes = 8'(n); addr_hi = ah; addr_lo = al;
    start = 1'b1;
    P = cyc + 1;
    mode = 1;
    @(posedge clk); #1;
    start = 1'b0;
    rw = 1'($urandom); nbytes = 8'($urandom); addr_hi = 8'($urandom); addr_lo = 8'($urandom);
  endtask

  task automatic run_txn(input bit wr_rd, input int n, input logic [7:0] ah, input logic [7:0] al,
                         input int nack_at, input int restart_r, input bit start_on_done);
    begin_txn(wr_rd, n, ah, al, nack_at);
    while (cyc < P + T * D + 3) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc - P == restart_r) begin
        start = 1'b1; rw = ~wr_rd; nbytes = 8'($urandom_range(1, 9));
        addr_hi = 8'($urandom); addr_lo = 8'($urandom);
      end
      if (start_on_done && cyc - P == T * D) begin
        start = 1'b1; rw = 1'b0; nbytes = 8'd1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int n, na, wr;
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'h00;
    reset_l = 1'b0; start = 1'b0; rw = 1'b0; nbytes = 8'h00; addr_hi = 8'h00; addr_lo = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_completed", completed, 1'b0);
    chk("rst_nack", nack_err, 1'b0);
    chk("rst_read_data", read_data, 8'h00);
    chk("rst_tx_req", tx_data_req, 1'b0);
    chk("rst_rx_ready", rx_data_ready, 1'b0);
    reset_l = 1'b1;
    mode = 0;
    repeat (2) @(posedge clk);

    // Write N=2 to 0x0123.
    wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C;
    run_txn(1'b0, 2, 8'h01, 8'h23, -1, -1, 1'b0);
    chk("w2_model_ticks", T, 188);
    chk("w2_done_latency", done_cyc - P, 188 * D);
    chk("w2_tx_pulses", tx_seen, 2);
    chk("w2_nack", nack_err, 1'b0);

    // Read N=3 from 0x0010, with a start while busy and a start during completed.
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33;
    run_txn(1'b1, 3, 8'h00, 8'h10, -1, 50 * D, 1'b1);
    chk("r3_model_ticks", T, 264);
    chk("r3_done_latency", done_cyc - P, 264 * D);
    chk("r3_rx_pulses", rx_seen, 3);
    chk("r3_byte0", rx_got[0], 8'h11);
    chk("r3_byte1", rx_got[1], 8'h22);
    chk("r3_byte2", rx_got[2], 8'h33);
    chk("r3_done_pulses", done_seen, 1);

    // Slave NACK on ADDR_L during a 4-byte write.
    for (int i = 0; i < 4; i++) wr_bytes[i] = 8'(8'h40 + i);
    run_txn(1'b0, 4, 8'h02, 8'h00, 2, -1, 1'b0);
    chk("nk_model_ticks", T, 4 + 108 + 4);
    chk("nk_tx_pulses", tx_seen, 0);
    chk("nk_nack", nack_err, 1'b1);
    chk("nk_done_pulses", done_seen, 1);

    // Address-only read; the new start clears nack_err.
    run_txn(1'b1, 0, 8'h00, 8'h00, -1, -1, 1'b0);
    chk("a0_model_ticks", T, 116);
    chk("a0_done_latency", done_cyc - P, 116 * D);
    chk("a0_nack_cleared", nack_err, 1'b0);
    chk("a0_rx_pulses", rx_seen, 0);

    // Reset in the middle of the first WDATA byte, bit 5 (SCL low, SDA pulled low).
    wr_bytes[0] = 8'hC3; wr_bytes[1] = 8'h5A;
    begin_txn(1'b0, 2, 8'h07, 8'h70, -1);
    while (cyc < P + 133 * D + 1) @(posedge clk);
    #1;
    chk("mid_scl_before", scl, 1'b0);
    chk("mid_sda_before", sda_oe, 1'b1);
    mode = 2;
    reset_l = 1'b0;
    #1;
    chk("mid_rst_scl", scl, 1'b1);
    chk("mid_rst_sda", sda_oe, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_completed", completed, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_l = 1'b1;
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    wr_bytes[0] = 8'h96;
    run_txn(1'b0, 1, 8'h12, 8'h34, -1, -1, 1'b0);
    chk("post_rst_latency", done_cyc - P, 152 * D);
    chk("post_rst_tx", tx_seen, 1);

    // Randomized transactions.
    for (int t = 0; t < 14; t++) begin
      wr = int'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 4));
      for (int i = 0; i < 8; i++) begin
        wr_bytes[i] = 8'($urandom);
        rd_bytes[i] = 8'($urandom);
      end
      na = -1;
      if ($urandom_range(0, 3) == 0)
        na = (wr == 0) ? int'($urandom_range(0, 2 + n)) : int'($urandom_range(0, (n > 0) ? 3 : 2));
      run_txn(wr == 1, n, 8'($urandom), 8'($urandom), na,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : -1,
              1'($urandom));
      chk("rnd_done_pulses", done_seen, 1);
      chk("rnd_tx_pulses", tx_seen, (wr == 0 && (na < 0 || na > 2)) ? ((na < 0) ? n : na - 2) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
